axi_slave_mem: RTL and testbench

AXI_SLAVE_MEM -- requirements
Module: axi_slave_mem

---
 rtl/axi_slave_mem.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_axi_slave_mem.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave_mem.sv
// AXI burst memory slave with independent read and write engines over a shared word array.
// Define AXI_MEM_SLVERR_EN to flag out-of-range addresses with SLVERR instead of wrapping.
module axi_slave_mem #(
    parameter int unsigned AWIDTH = 32,
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DEPTH  = 256
) (
    input  logic               ACLK,
    input  logic               ARESETn,
    input  logic [3:0]         AWID,
    input  logic [AWIDTH-1:0]  AWADDR,
    input  logic [7:0]         AWLEN,
    input  logic [2:0]         AWSIZE,
    input  logic [1:0]         AWBURST,
    input  logic               AWVALID,
    output logic               AWREADY,
    input  logic [3:0]         WID,
    input  logic [WIDTH-1:0]   WDATA,
    input  logic [WIDTH/8-1:0] WSTRB,
    input  logic               WLAST,
    input  logic               WVALID,
    output logic               WREADY,
    output logic [3:0]         BID,
    output logic [1:0]         BRESP,
    output logic               BVALID,
    input  logic               BREADY,
    input  logic [3:0]         ARID,
    input  logic [AWIDTH-1:0]  ARADDR,
    input  logic [7:0]         ARLEN,
    input  logic [2:0]         ARSIZE,
    input  logic [1:0]         ARBURST,
    input  logic               ARVALID,
    output logic               ARREADY,
    output logic [3:0]         RID,
    output logic [WIDTH-1:0]   RDATA,
    output logic [1:0]         RRESP,
    output logic               RLAST,
    output logic               RVALID,
    input  logic               RREADY
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int STRB_W = WIDTH / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    function automatic logic [AWIDTH-1:0] next_addr(input logic [AWIDTH-1:0] addr,
                                                    input logic [2:0]        size,
                                                    input logic [7:0]        len,
                                                    input logic [1:0]        burst);
        logic [AWIDTH-1:0] step;
        logic [AWIDTH-1:0] incr;
        logic [AWIDTH-1:0] mask;
        logic              wrap_len;
        step     = AWIDTH'(1) << size;
        incr     = addr + step;
        mask     = ((AWIDTH'(len) + AWIDTH'(1)) << size) - AWIDTH'(1);
        wrap_len = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        next_addr = incr;
        if (burst == BURST_FIXED) begin
            next_addr = addr;
        end else if (burst == BURST_WRAP && wrap_len) begin
            next_addr = (addr & ~mask) | (incr & mask);
        end
    endfunction

    function automatic logic burst_err(input logic [1:0] burst, input logic [2:0] size);
        burst_err = (burst == BURST_RSVD) || (size > 3'd2);
    endfunction

    logic [WIDTH-1:0] mem [DEPTH];

    // Holds both READY outputs low until the first edge after reset release.
    logic ready_q;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    // ---------------------------------------------------------------- write path
    w_state_e          w_state_q, w_state_d;
    logic [3:0]        aw_id_q;
    logic [AWIDTH-1:0] w_addr_q;
    logic [7:0]        aw_len_q;
    logic [2:0]        aw_size_q;
    logic [1:0]        aw_burst_q;
    logic [7:0]        w_cnt_q;
    logic              w_bad_q;
    logic              w_err_q;
    logic              w_over_q;
    logic [1:0]        bresp_q;

    logic aw_hs, w_hs;
    logic w_range_err, w_beat_err, w_mismatch, w_err_next, w_we;

    always_comb begin
        w_state_d = w_state_q;
        AWREADY   = 1'b0;
        WREADY    = 1'b0;
        BVALID    = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
                AWREADY = ready_q;
                if (AWVALID && ready_q) w_state_d = W_DATA;
            end
            W_DATA: begin
                WREADY = 1'b1;
                if (WVALID && WLAST) w_state_d = W_RESP;
            end
            W_RESP: begin
                BVALID = 1'b1;
                if (BREADY) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state_q <= W_IDLE;
        end else begin
            w_state_q <= w_state_d;
        end
    end

    assign aw_hs = AWVALID && AWREADY;
    assign w_hs  = WVALID && WREADY;

`ifdef AXI_MEM_SLVERR_EN
    assign w_range_err = |w_addr_q[AWIDTH-1:IDX_W+2];
`else
    assign w_range_err = 1'b0;
`endif

    // Early WLAST ends the burst; missing WLAST on the final beat drains extra beats unwritten.
    assign w_mismatch = WLAST ? (w_cnt_q != aw_len_q) : (w_cnt_q == aw_len_q);
    assign w_beat_err = w_bad_q || w_range_err;
    assign w_err_next = w_err_q || w_beat_err || w_mismatch;
    assign w_we       = w_hs && !w_beat_err && !w_over_q;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            aw_id_q    <= '0;
            w_addr_q   <= '0;
            aw_len_q   <= '0;
            aw_size_q  <= '0;
            aw_burst_q <= '0;
            w_cnt_q    <= '0;
            w_bad_q    <= 1'b0;
            w_err_q    <= 1'b0;
            w_over_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
        end else if (aw_hs) begin
            aw_id_q    <= AWID;
            w_addr_q   <= AWADDR;
            aw_len_q   <= AWLEN;
            aw_size_q  <= AWSIZE;
            aw_burst_q <= AWBURST;
            w_cnt_q    <= '0;
            w_bad_q    <= burst_err(AWBURST, AWSIZE);
            w_err_q    <= 1'b0;
            w_over_q   <= 1'b0;
        end else if (w_hs) begin
            w_addr_q <= next_addr(w_addr_q, aw_size_q, aw_len_q, aw_burst_q);
            w_cnt_q  <= w_cnt_q + 8'd1;
            w_err_q  <= w_err_next;
            if (!WLAST && w_cnt_q == aw_len_q) w_over_q <= 1'b1;
            if (WLAST) bresp_q <= w_err_next ? RESP_SLVERR : RESP_OKAY;
        end
    end

    always_ff @(posedge ACLK) begin
        if (w_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (WSTRB[b]) mem[w_addr_q[IDX_W+1:2]][b*8 +: 8] <= WDATA[b*8 +: 8];
            end
        end
    end

    assign BID   = aw_id_q;
    assign BRESP = bresp_q;

    // ----------------------------------------------------------------- read path
    r_state_e          r_state_q, r_state_d;
    logic [3:0]        ar_id_q;
    logic [AWIDTH-1:0] r_addr_q;
    logic [7:0]        ar_len_q;
    logic [2:0]        ar_size_q;
    logic [1:0]        ar_burst_q;
    logic [7:0]        r_cnt_q;
    logic              r_bad_q;
    logic [WIDTH-1:0]  rdata_q;
    logic [1:0]        rresp_q;
    logic              rlast_q;

    logic              ar_hs, r_hs, r_load;
    logic [AWIDTH-1:0] r_src_addr;
    logic [7:0]        r_src_len;
    logic [2:0]        r_src_size;
    logic [1:0]        r_src_burst;
    logic              r_src_bad, r_range_err, r_beat_err;

    always_comb begin
        r_state_d = r_state_q;
        ARREADY   = 1'b0;
        RVALID    = 1'b0;
        unique case (r_state_q)
            R_IDLE: begin
                ARREADY = ready_q;
                if (ARVALID && ready_q) r_state_d = R_DATA;
            end
            R_DATA: begin
                RVALID = 1'b1;
                if (RREADY && rlast_q) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state_q <= R_IDLE;
        end else begin
            r_state_q <= r_state_d;
        end
    end

    assign ar_hs  = ARVALID && ARREADY;
    assign r_hs   = RVALID && RREADY;
    assign r_load = ar_hs || (r_hs && !rlast_q);

    // The beat being loaded comes straight from AR on acceptance, else from the running address.
    always_comb begin
        r_src_addr  = r_addr_q;
        r_src_len   = ar_len_q;
        r_src_size  = ar_size_q;
        r_src_burst = ar_burst_q;
        r_src_bad   = r_bad_q;
        if (ar_hs) begin
            r_src_addr  = ARADDR;
            r_src_len   = ARLEN;
            r_src_size  = ARSIZE;
            r_src_burst = ARBURST;
            r_src_bad   = burst_err(ARBURST, ARSIZE);
        end
    end

`ifdef AXI_MEM_SLVERR_EN
    assign r_range_err = |r_src_addr[AWIDTH-1:IDX_W+2];
`else
    assign r_range_err = 1'b0;
`endif

    assign r_beat_err = r_src_bad || r_range_err;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            ar_id_q    <= '0;
            r_addr_q   <= '0;
            ar_len_q   <= '0;
            ar_size_q  <= '0;
            ar_burst_q <= '0;
            r_cnt_q    <= '0;
            r_bad_q    <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            rlast_q    <= 1'b0;
        end else begin
            if (ar_hs) begin
                ar_id_q    <= ARID;
                ar_len_q   <= ARLEN;
                ar_size_q  <= ARSIZE;
                ar_burst_q <= ARBURST;
                r_bad_q    <= r_src_bad;
                r_cnt_q    <= '0;
            end else if (r_hs && !rlast_q) begin
                r_cnt_q <= r_cnt_q + 8'd1;
            end
            if (r_load) begin
                r_addr_q <= next_addr(r_src_addr, r_src_size, r_src_len, r_src_burst);
                rdata_q  <= r_beat_err ? '0 : mem[r_src_addr[IDX_W+1:2]];
                rresp_q  <= r_beat_err ? RESP_SLVERR : RESP_OKAY;
                rlast_q  <= ar_hs ? (ARLEN == 8'd0) : (r_cnt_q + 8'd1 == ar_len_q);
            end else if (r_hs) begin
                rdata_q <= '0;
                rresp_q <= RESP_OKAY;
                rlast_q <= 1'b0;
            end
        end
    end

    assign RID   = ar_id_q;
    assign RDATA = rdata_q;
    assign RRESP = rresp_q;
    assign RLAST = rlast_q;

    logic unused_wid;
    assign unused_wid = ^WID;

endmodule

// File: tb/tb_axi_slave_mem.sv
// Scoreboard bench for axi_slave_mem: directed bursts push expected B/R responses,
// a monitor pops and compares them whenever the DUT hands a response over.
`timescale 1ns/1ps
module tb_axi_slave_mem;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic [3:0]  AWID = '0;
    logic [31:0] AWADDR = '0;
    logic [7:0]  AWLEN = '0;
    logic [2:0]  AWSIZE = '0;
    logic [1:0]  AWBURST = '0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [3:0]  WID = '0;
    logic [31:0] WDATA = '0;
    logic [3:0]  WSTRB = '0;
    logic        WLAST = 1'b0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [3:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY = 1'b1;
    logic [3:0]  ARID = '0;
    logic [31:0] ARADDR = '0;
    logic [7:0]  ARLEN = '0;
    logic [2:0]  ARSIZE = '0;
    logic [1:0]  ARBURST = '0;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [3:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY = 1'b1;

    axi_slave_mem dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID),
        .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
        .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;
    localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10, RSVD = 2'b11;

    typedef struct { logic [3:0] id; logic [1:0] resp; } b_exp_t;
    typedef struct { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_exp_t;

    b_exp_t      exp_b[$];
    r_exp_t      exp_r[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    bit          stall_mode = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got %s", name, what);
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST, BID, BRESP, RID, RRESP,
                    RDATA});
    endfunction

    task automatic push_r(input logic [3:0] id, input logic [31:0] data, input logic [1:0] resp,
                          input logic last);
        r_exp_t e;
        e.id = id; e.data = data; e.resp = resp; e.last = last;
        exp_r.push_back(e);
    endtask

    task automatic wait_ready(input int which, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge ACLK);
            case (which)
                0:       seen = AWREADY;
                1:       seen = WREADY;
                default: seen = ARREADY;
            endcase
            if (seen) break;
        end
        if (!seen) fail_now(name, "ready timeout, expected ready=1");
        @(posedge ACLK);
        #1;
    endtask

    task automatic wait_queue(input bit is_r, input string name);
        bit done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge ACLK);
            #1;
            done = is_r ? (exp_r.size() == 0) : (exp_b.size() == 0);
            if (done) break;
        end
        if (!done) fail_now(name, "response timeout, expected all responses");
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int nbeats,
                            input logic [1:0] resp, input bit hold);
        b_exp_t e;
        e.id = id; e.resp = resp;
        exp_b.push_back(e);
        if (hold) BREADY = 1'b0;
        AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
        wait_ready(0, "aw_ready");
        AWVALID = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            WID = 4'hF - id;
            WDATA = wd[b]; WSTRB = ws[b]; WLAST = (b == nbeats - 1); WVALID = 1'b1;
            wait_ready(1, "w_ready");
        end
        WVALID = 1'b0;
        WLAST = 1'b0;
        if (hold) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge ACLK);
                check("b_hold_valid", 64'(BVALID), 64'd1);
                check("b_hold_resp", 64'({BID, BRESP}), 64'({id, resp}));
            end
            @(posedge ACLK);
            #1;
            BREADY = 1'b1;
        end
        wait_queue(1'b0, "b_done");
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
        wait_ready(2, "ar_ready");
        ARVALID = 1'b0;
        @(negedge ACLK);
        check("ar_latency", 64'(RVALID), 64'd1);
        wait_queue(1'b1, "r_done");
    endtask

    task automatic set_w(input logic [31:0] base, input int n, input logic [3:0] strb);
        for (int i = 0; i < n; i++) begin
            wd[i] = base + 32'(i);
            ws[i] = strb;
        end
    endtask

    // RREADY driver: always ready, or the repeating 1,0,0,1 stall pattern.
    initial begin
        bit [3:0] rpat;
        int       ph;
        rpat = 4'b1001;
        ph = 0;
        forever begin
            @(posedge ACLK);
            #1;
            if (stall_mode) begin
                RREADY = rpat[ph];
                ph = (ph + 1) % 4;
            end else begin
                RREADY = 1'b1;
                ph = 0;
            end
        end
    end

    // Monitor: compares every B and R handshake against the scoreboard and checks R holds.
    initial begin
        b_exp_t      eb;
        r_exp_t      er;
        bit          r_stall;
        logic [63:0] held;
        r_stall = 1'b0;
        held = '0;
        forever begin
            @(negedge ACLK);
            if (!ARESETn) begin
                r_stall = 1'b0;
            end else begin
                if (BVALID && BREADY) begin
                    if (exp_b.size() == 0) begin
                        fail_now("b_unexpected", "unexpected B response");
                    end else begin
                        eb = exp_b.pop_front();
                        check("b_resp", 64'({BID, BRESP}), 64'({eb.id, eb.resp}));
                    end
                end
                if (RVALID) begin
                    if (r_stall) check("r_hold", 64'({RID, RRESP, RLAST, RDATA}), held);
                    if (RREADY) begin
                        r_stall = 1'b0;
                        if (exp_r.size() == 0) begin
                            fail_now("r_unexpected", "unexpected R beat");
                        end else begin
                            er = exp_r.pop_front();
                            check("r_beat", 64'({RID, RDATA, RRESP, RLAST}),
                                  64'({er.id, er.data, er.resp, er.last}));
                        end
                    end else begin
                        r_stall = 1'b1;
                        held = 64'({RID, RRESP, RLAST, RDATA});
                    end
                end else begin
                    r_stall = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset behaviour and READY rising on the first edge after release.
        repeat (3) @(posedge ACLK);
        #1;
        check("rst_outputs", all_outputs(), 64'd0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        #1;
        check("rdy_before_edge", 64'({AWREADY, ARREADY}), 64'd0);
        @(posedge ACLK);
        #1;
        check("rdy_after_edge", 64'({AWREADY, ARREADY}), 64'b11);

        // INCR write then read back.
        set_w(32'hA0, 4, 4'hF);
        do_write(4'd3, 32'h10, 8'd3, 3'd2, INCR, 4, OKAY, 1'b0);
        for (int i = 0; i < 4; i++) push_r(4'd5, 32'hA0 + 32'(i), OKAY, i == 3);
        do_read(4'd5, 32'h10, 8'd3, 3'd2, INCR);

        // Byte-lane merge; BVALID held while BREADY is low.
        wd[0] = 32'hFFFF_FFFF; ws[0] = 4'hF;
        do_write(4'd1, 32'h40, 8'd0, 3'd2, INCR, 1, OKAY, 1'b1);
        wd[0] = 32'h1234_5678; ws[0] = 4'b0101;
        do_write(4'd2, 32'h40, 8'd0, 3'd2, INCR, 1, OKAY, 1'b0);
        push_r(4'd6, 32'hFF34_FF78, OKAY, 1'b1);
        do_read(4'd6, 32'h40, 8'd0, 3'd2, INCR);

        // WRAP window 0x30..0x3F starting at 0x38; non-power LEN wraps as INCR.
        set_w(32'hB0, 4, 4'hF);
        do_write(4'd4, 32'h30, 8'd3, 3'd2, INCR, 4, OKAY, 1'b0);
        set_w(32'hC0, 4, 4'hF);
        do_write(4'd4, 32'h38, 8'd3, 3'd2, WRAP, 4, OKAY, 1'b0);
        push_r(4'd7, 32'hC2, OKAY, 1'b0);
        push_r(4'd7, 32'hC3, OKAY, 1'b0);
        push_r(4'd7, 32'hC0, OKAY, 1'b0);
        push_r(4'd7, 32'hC1, OKAY, 1'b1);
        do_read(4'd7, 32'h30, 8'd3, 3'd2, INCR);
        for (int i = 0; i < 4; i++) push_r(4'd7, 32'hC0 + 32'(i), OKAY, i == 3);
        do_read(4'd7, 32'h38, 8'd3, 3'd2, WRAP);
        push_r(4'd8, 32'hC0, OKAY, 1'b0);
        push_r(4'd8, 32'hC1, OKAY, 1'b0);
        push_r(4'd8, 32'hFF34_FF78, OKAY, 1'b1);
        do_read(4'd8, 32'h38, 8'd2, 3'd2, WRAP);
        push_r(4'd8, 32'hC0, OKAY, 1'b0);
        push_r(4'd8, 32'hC0, OKAY, 1'b1);
        do_read(4'd8, 32'h38, 8'd1, 3'd2, FIXED);

        // Eight-beat read with RREADY stalls.
        set_w(32'hD0, 8, 4'hF);
        do_write(4'd7, 32'h80, 8'd7, 3'd2, INCR, 8, OKAY, 1'b0);
        stall_mode = 1'b1;
        for (int i = 0; i < 8; i++) push_r(4'd9, 32'hD0 + 32'(i), OKAY, i == 7);
        do_read(4'd9, 32'h80, 8'd7, 3'd2, INCR);
        stall_mode = 1'b0;

        // WLAST early, WLAST late, reserved burst and oversize beats.
        set_w(32'hE0, 2, 4'hF);
        do_write(4'd9, 32'h60, 8'd3, 3'd2, INCR, 2, SLVERR, 1'b0);
        set_w(32'h11, 3, 4'hF);
        do_write(4'd10, 32'h70, 8'd2, 3'd2, INCR, 3, OKAY, 1'b0);
        set_w(32'hF0, 3, 4'hF);
        do_write(4'd11, 32'h70, 8'd1, 3'd2, INCR, 3, SLVERR, 1'b0);
        push_r(4'd10, 32'hF0, OKAY, 1'b0);
        push_r(4'd10, 32'hF1, OKAY, 1'b0);
        push_r(4'd10, 32'h13, OKAY, 1'b1);
        do_read(4'd10, 32'h70, 8'd2, 3'd2, INCR);
        wd[0] = 32'h0; ws[0] = 4'hF;
        do_write(4'd12, 32'h40, 8'd0, 3'd2, RSVD, 1, SLVERR, 1'b0);
        push_r(4'd11, 32'h0, SLVERR, 1'b1);
        do_read(4'd11, 32'h40, 8'd0, 3'd2, RSVD);
        push_r(4'd11, 32'hFF34_FF78, OKAY, 1'b1);
        do_read(4'd11, 32'h40, 8'd0, 3'd2, INCR);
        push_r(4'd12, 32'h0, SLVERR, 1'b1);
        do_read(4'd12, 32'h40, 8'd0, 3'd3, INCR);

        // Out-of-range address: SLVERR with the option, modulo wrap without it.
        wd[0] = 32'h600D_F00D; ws[0] = 4'hF;
        do_write(4'd13, 32'h0, 8'd0, 3'd2, INCR, 1, OKAY, 1'b0);
        wd[0] = 32'hDEAD_BEEF;
`ifdef AXI_MEM_SLVERR_EN
        do_write(4'd13, 32'h400, 8'd0, 3'd2, INCR, 1, SLVERR, 1'b0);
        push_r(4'd13, 32'h600D_F00D, OKAY, 1'b1);
        do_read(4'd13, 32'h0, 8'd0, 3'd2, INCR);
        push_r(4'd13, 32'h0, SLVERR, 1'b1);
        do_read(4'd13, 32'h400, 8'd0, 3'd2, INCR);
`else
        do_write(4'd13, 32'h400, 8'd0, 3'd2, INCR, 1, OKAY, 1'b0);
        push_r(4'd13, 32'hDEAD_BEEF, OKAY, 1'b1);
        do_read(4'd13, 32'h0, 8'd0, 3'd2, INCR);
        push_r(4'd13, 32'hDEAD_BEEF, OKAY, 1'b1);
        do_read(4'd13, 32'h400, 8'd0, 3'd2, INCR);
`endif

        // Concurrent write and read bursts.
        set_w(32'h77, 2, 4'hF);
        fork
            do_write(4'd14, 32'h90, 8'd1, 3'd2, INCR, 2, OKAY, 1'b0);
            begin
                for (int i = 0; i < 4; i++) push_r(4'd15, 32'hA0 + 32'(i), OKAY, i == 3);
                do_read(4'd15, 32'h10, 8'd3, 3'd2, INCR);
            end
        join
        push_r(4'd14, 32'h77, OKAY, 1'b0);
        push_r(4'd14, 32'h78, OKAY, 1'b1);
        do_read(4'd14, 32'h90, 8'd1, 3'd2, INCR);

        // Reset while the second read beat is on the bus.
        push_r(4'd1, 32'hD0, OKAY, 1'b0);
        ARID = 4'd1; ARADDR = 32'h80; ARLEN = 8'd7; ARSIZE = 3'd2; ARBURST = INCR;
        ARVALID = 1'b1;
        wait_ready(2, "ar_ready_rst");
        ARVALID = 1'b0;
        @(posedge ACLK);
        #1;
        ARESETn = 1'b0;
        #1;
        check("rst_rvalid", 64'(RVALID), 64'd0);
        repeat (2) @(posedge ACLK);
        #1;
        check("rst_mid_outputs", all_outputs(), 64'd0);
        check("rst_r_beats_left", 64'(exp_r.size()), 64'd0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        #1;
        check("rst2_rdy_before_edge", 64'({AWREADY, ARREADY}), 64'd0);
        @(posedge ACLK);
        #1;
        check("rst2_rdy_after_edge", 64'({AWREADY, ARREADY}), 64'b11);
        push_r(4'd2, 32'hD0, OKAY, 1'b0);
        push_r(4'd2, 32'hD1, OKAY, 1'b1);
        do_read(4'd2, 32'h80, 8'd1, 3'd2, INCR);

        repeat (3) @(posedge ACLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
